// File: rtl/reg_file_nport.sv
// Parametrised register file: one write port, READ_PORTS registered read ports, optional zero register.
// Optional write-first bypass when REGFILE_BYPASS_EN is defined; default build is read-first.
module reg_file_nport #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned ZERO_REG   = 1,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [READ_PORTS-1:0] rd_en,
  input  logic [AW-1:0]         rd_addr [READ_PORTS],
  output logic [WIDTH-1:0]      rd_data [READ_PORTS]
);

  localparam int unsigned AW1 = AW + 1;

  logic [WIDTH-1:0] r_mem     [DEPTH];
  logic [WIDTH-1:0] r_rd_data [READ_PORTS];
  logic [WIDTH-1:0] w_rd_val  [READ_PORTS];
  logic             w_wr_ok;

  // A write lands only on an in-range entry that is not the hardwired zero register
  always_comb begin
    w_wr_ok = wr_en && ({1'b0, wr_addr} < AW1'(DEPTH));
    if ((ZERO_REG != 0) && ({1'b0, wr_addr} == AW1'(DEPTH - 1))) begin
      w_wr_ok = 1'b0;
    end
  end

  // Decoded read mux; unmatched (out-of-range) and zero-register addresses yield 0
  always_comb begin
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      w_rd_val[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((rd_addr[p] == AW'(i)) && !((ZERO_REG != 0) && (i == DEPTH - 1))) begin
          w_rd_val[p] = r_mem[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (wr_addr == rd_addr[p])) begin
        w_rd_val[p] = wr_data;
      end
`endif
    end
  end

  // Storage array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && (wr_addr == AW'(i))) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  // Registered read ports; a disabled port holds its last value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned p = 0; p < READ_PORTS; p++) begin
        r_rd_data[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < READ_PORTS; p++) begin
        if (rd_en[p]) begin
          r_rd_data[p] <= w_rd_val[p];
        end
      end
    end
  end

  assign rd_data = r_rd_data;

endmodule
